// File: rtl/alu.sv
// Registered WIDTH-bit ALU: ADD/SUB/AND/OR with NZCV flags.
// The operands are sampled on the rising edge when in_valid is high.
// Result and ALUFlags appear one cycle later, qualified by out_valid.
// All outputs come straight from flops, so there is no combinational
// path from any input to any output.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Signed overflow for A + B: the operands agree in sign and the result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow for A - B: the operands differ in sign and the result differs from A.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] b_op_s;
    logic             cin_s;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_d;
    logic             carry_s;
    logic             ovf_s;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             valid_q;

    // Shared adder: SUB reuses the ADD path by inverting B and injecting a carry-in.
    always_comb begin
        b_op_s = B;
        cin_s  = 1'b0;
        if (ALUControl == OP_SUB) begin
            b_op_s = ~B;
            cin_s  = 1'b1;
        end else begin
            b_op_s = B;
            cin_s  = 1'b0;
        end
        sum_s = {1'b0, A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Select the result and build the NZCV flags for the selected operation.
    always_comb begin
        result_d = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                result_d = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = add_ovf(A[WIDTH-1], B[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                result_d = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = sub_ovf(A[WIDTH-1], B[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_AND: begin
                result_d = A & B;
            end
            OP_OR: begin
                result_d = A | B;
            end
            default: begin
                result_d = {WIDTH{1'b0}};
            end
        endcase
        flags_d = {result_d[WIDTH-1], (result_d == {WIDTH{1'b0}}), carry_s, ovf_s};
    end

    // Output registers: capture on in_valid, otherwise hold; out_valid marks a fresh capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign Result    = result_q;
    assign ALUFlags  = flags_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu.
// The driver pushes hand-computed expectations into a queue.
// The monitor pops one entry whenever out_valid is high. While out_valid is
// low, it checks that Result and ALUFlags keep the last value they produced.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] ALUControl;
    logic [3:0] Result;
    logic [3:0] ALUFlags;
    logic       out_valid;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] flags;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    alu #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    // Issue one valid operation and record its expected response.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] ctl,
                      input logic [3:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        A          = a;
        B          = b;
        ALUControl = ctl;
        e.res      = er;
        e.flags    = ef;
        q.push_back(e);
    endtask

    // Idle cycle with changed operands that must not be captured.
    task automatic idle(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid   = 1'b0;
        A          = a;
        B          = b;
        ALUControl = 2'b00;
    endtask

    // Monitor: compare each presented output against the scoreboard.
    initial begin
        exp_t       e;
        logic [3:0] last_res;
        logic [3:0] last_flags;
        last_res   = 4'b0000;
        last_flags = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_res   = 4'b0000;
                last_flags = 4'b0000;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    check("result", {4'b0000, Result}, {4'b0000, e.res});
                    check("flags", {4'b0000, ALUFlags}, {4'b0000, e.flags});
                    last_res   = e.res;
                    last_flags = e.flags;
                end
            end else begin
                if (q.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_out_valid: actual=0 required=1");
                end
                check("hold_result", {4'b0000, Result}, {4'b0000, last_res});
                check("hold_flags", {4'b0000, ALUFlags}, {4'b0000, last_flags});
            end
        end
    end

    // Stimulus and reset checks.
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = 4'b0000;
        B          = 4'b0000;
        ALUControl = 2'b00;
        @(posedge clk);
        #2;
        check("reset_result", {4'b0000, Result}, 8'h00);
        check("reset_flags", {4'b0000, ALUFlags}, 8'h00);
        check("reset_valid", {7'b0000000, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic operations.
        op(4'b0101, 4'b0010, 2'b11, 4'b0111, 4'b0000);
        op(4'b0010, 4'b0101, 2'b10, 4'b0000, 4'b0100);
        idle(4'b0000, 4'b0000);
        // ADD.
        op(4'b0111, 4'b0100, 2'b00, 4'b1011, 4'b1001);
        op(4'b1111, 4'b0001, 2'b00, 4'b0000, 4'b0110);
        idle(4'b0000, 4'b0000);
        // SUB.
        op(4'b0101, 4'b0011, 2'b01, 4'b0010, 4'b0010);
        op(4'b0011, 4'b0101, 2'b01, 4'b1110, 4'b1000);
        op(4'b1000, 4'b0001, 2'b01, 4'b0111, 4'b0011);
        // Valid gating: a single op, then idle cycles with changed operands.
        op(4'b0001, 4'b0001, 2'b00, 4'b0010, 4'b0000);
        idle(4'b1111, 4'b1111);
        idle(4'b1010, 4'b0101);
        idle(4'b0110, 4'b1001);
        // Back-to-back operations.
        op(4'b0011, 4'b0100, 2'b00, 4'b0111, 4'b0000);
        op(4'b0000, 4'b0001, 2'b01, 4'b1111, 4'b1000);
        op(4'b1100, 4'b1010, 2'b10, 4'b1000, 4'b1000);
        op(4'b1001, 4'b0110, 2'b11, 4'b1111, 4'b1000);
        idle(4'b0000, 4'b0000);
        idle(4'b0000, 4'b0000);

        // Mid-cycle asynchronous reset after a capture.
        op(4'b0010, 4'b0011, 2'b00, 4'b0101, 4'b0000);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_reset_result", {4'b0000, Result}, 8'h00);
        check("async_reset_flags", {4'b0000, ALUFlags}, 8'h00);
        check("async_reset_valid", {7'b0000000, out_valid}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4'b1111, 4'b1111);
        idle(4'b1111, 4'b1111);
        @(negedge clk);

        check("scoreboard_drained", q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 4-bit arithmetic/logic unit for the datapath execute stage. Each cycle it computes add, subtract, AND or OR of two operands selected by a 2-bit control code. It produces the result and a 4-bit NZCV condition flag vector. Outputs are registered with one cycle of latency and qualified by a valid strobe, so the block can sit directly between pipeline registers.

## Interface

One clock; reset is asynchronous and active-low.

**Parameters**
- WIDTH, default 4, operand/result width in bits; must be ≥ 2.

**Ports**
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and control are valid this cycle.
- A  input  WIDTH  operand A (two's complement or unsigned).
- B  input  WIDTH  operand B.
- ALUControl  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- Result  output  WIDTH  registered operation result.
- ALUFlags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- out_valid  output  1  Result/ALUFlags hold a newly computed value.

## Operation

**Arithmetic**
- ADD (00): sum = A + B, computed at WIDTH+1 bits; Result = sum[WIDTH-1:0].
- SUB (01): sum = A + ~B + 1 at WIDTH+1 bits; Result = (A − B) mod 2^WIDTH.
- AND (10): Result = A & B.
- OR (11): Result = A | B.

**Flags**
- N = Result[WIDTH-1].
- Z = 1 iff Result == 0.
- C, ADD/SUB: carry out, sum[WIDTH]. For SUB, C=1 means no borrow (A ≥ B unsigned), per ARM convention.
- C, logic ops: 0.
- V, ADD: A and B have the same sign and Result's sign differs.
- V, SUB: A and B have different signs and Result's sign differs from A.
- V, logic ops: 0.

**Valid handling**
- All four control codes are legal; there is no illegal-op behaviour.
- When in_valid=1, Result and ALUFlags register the new computation and out_valid=1 on the following cycle.
- When in_valid=0, Result and ALUFlags hold their previous values and out_valid=0.

## Timing

- Latency is exactly 1 clock: inputs sampled at rising edge k appear on the outputs after edge k.
- Throughput is one operation per cycle; back-to-back in_valid is supported, with no stalls and no backpressure.
- Reset (rst_n=0) asynchronously forces Result=0, ALUFlags=4'b0000 and out_valid=0, independent of clk.
- Reset mid-operation discards the in-flight result.
- After rst_n deasserts, the first capture occurs at the first rising edge with in_valid=1.
- Inputs must be stable around the sampling edge; no combinational path runs from input to output.

## Test plan

- Reset: assert rst_n=0 mid-cycle → Result=0000, ALUFlags=0000, out_valid=0 immediately, without waiting for a clock edge.
- Logic ops, each with in_valid=1:
  - A=0101, B=0010, OR → Result=0111, flags 0000.
  - A=0010, B=0101, AND → Result=0000, flags 0100 (Z).
  - Both appear one cycle after sampling.
- ADD:
  - A=0111, B=0100 → Result=1011, flags 1001 (N, V).
  - A=1111, B=0001 → Result=0000, flags 0110 (Z, C).
- SUB:
  - A=0101, B=0011 → Result=0010, flags 0010 (C).
  - A=0011, B=0101 → Result=1110, flags 1000 (N, borrow).
  - A=1000, B=0001 → Result=0111, flags 0011 (C, V).
- Valid gating: one in_valid=1 op, then in_valid=0 with changed A/B → out_valid pulses for exactly one cycle; Result/ALUFlags hold the last computed values.
- Back-to-back: four consecutive valid ops → four consecutive out_valid cycles, each result matching its op one cycle later.
